ldpc_dec_sched: RTL and testbench

LDPC_DEC_SCHED -- requirements
Module: ldpc_dec_sched

---
 rtl/ldpc_dec_sched.sv | 182 ++++++++++++++++++
 tb/tb_ldpc_dec_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_dec_sched.sv
// LDPC decoder iteration scheduler: loads hard bits, runs
// datapath iterations until parity holds or limit, drains result.
module ldpc_dec_sched #(
  parameter int NN = 'h0d0,
  parameter int MM = 'h0a8,
  parameter int IW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [IW-1:0] max_iter_i,
  input  logic          in_valid_i,
  input  logic          in_bit_i,
  output logic          in_ready_o,
  output logic          ld_we_o,
  output logic [7:0]    ld_addr_o,
  output logic          ld_bit_o,
  output logic          dp_start_o,
  input  logic          dp_done_i,
  input  logic          syn_zero_i,
  output logic [7:0]    rd_addr_o,
  input  logic          dec_bit_i,
  output logic          out_valid_o,
  output logic          out_bit_o,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          success_o,
  output logic [IW-1:0] iter_cnt_o
);

  // Addresses are 8 bits wide, so the codeword must fit.
  if (NN < 1 || NN > 256 || MM < 1) begin : g_bad_cfg
    $error("ldpc_dec_sched: unsupported NN/MM");
  end

  localparam logic [7:0]    LAST = 8'(NN - 1);
  localparam logic [IW-1:0] IMAX = {IW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_WAIT, S_EVAL, S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] lim_q, lim_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          succ_q, succ_d;
  logic          ld_we_q, ld_we_d;
  logic [7:0]    ld_addr_q, ld_addr_d;
  logic          ld_bit_q, ld_bit_d;
  logic          done_q, done_d;
  logic          in_ready_q;
  logic          dp_start_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [7:0]    rd_addr_q;

  // Next-state and datapath-control decode; abort overrides all.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    iter_d    = iter_q;
    succ_d    = succ_q;
    ld_we_d   = 1'b0;
    ld_addr_d = ld_addr_q;
    ld_bit_d  = ld_bit_q;
    done_d    = 1'b0;
    if (abort_i) begin
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        succ_d  = 1'b0;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            lim_d   = (max_iter_i == '0) ? IW'(1) : max_iter_i;
            iter_d  = '0;
            succ_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid_i) begin
            ld_we_d   = 1'b1;
            ld_addr_d = cnt_q;
            ld_bit_d  = in_bit_i;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = S_RUN;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_RUN: state_d = S_WAIT;
        S_WAIT: begin
          if (dp_done_i) begin
            if (iter_q != IMAX) iter_d = iter_q + IW'(1);
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          if (syn_zero_i) begin
            succ_d  = 1'b1;
            state_d = S_DRAIN;
          end else if (iter_q >= lim_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if (out_ready_i) begin
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lim_q       <= '0;
      iter_q      <= '0;
      succ_q      <= 1'b0;
      ld_we_q     <= 1'b0;
      ld_addr_q   <= '0;
      ld_bit_q    <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      dp_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      iter_q      <= iter_d;
      succ_q      <= succ_d;
      ld_we_q     <= ld_we_d;
      ld_addr_q   <= ld_addr_d;
      ld_bit_q    <= ld_bit_d;
      done_q      <= done_d;
      in_ready_q  <= (state_d == S_LOAD);
      dp_start_q  <= (state_d == S_RUN);
      out_valid_q <= (state_d == S_DRAIN);
      busy_q      <= (state_d != S_IDLE);
      rd_addr_q   <= (state_d == S_DRAIN) ? cnt_d : 8'd0;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign ld_we_o     = ld_we_q;
  assign ld_addr_o   = ld_addr_q;
  assign ld_bit_o    = ld_bit_q;
  assign dp_start_o  = dp_start_q;
  assign rd_addr_o   = rd_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_bit_o   = dec_bit_i;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign success_o   = succ_q;
  assign iter_cnt_o  = iter_q;

endmodule

// File: tb/tb_ldpc_dec_sched.sv
// Directed bench for ldpc_dec_sched with a small
// behavioural datapath model.
module tb_ldpc_dec_sched;
  localparam int NN = 12;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [IW-1:0] max_iter_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_bit_i = 1'b0;
  logic          in_ready_o;
  logic          ld_we_o;
  logic [7:0]    ld_addr_o;
  logic          ld_bit_o;
  logic          dp_start_o;
  logic          dp_done_i = 1'b0;
  logic          syn_zero_i = 1'b0;
  logic [7:0]    rd_addr_o;
  logic          dec_bit_i;
  logic          out_valid_o;
  logic          out_bit_o;
  logic          out_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic          success_o;
  logic [IW-1:0] iter_cnt_o;

  always #5 clk = ~clk;

  ldpc_dec_sched #(.NN(NN), .MM(8), .IW(IW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .start_i(start_i), .abort_i(abort_i),
    .max_iter_i(max_iter_i),
    .in_valid_i(in_valid_i), .in_bit_i(in_bit_i),
    .in_ready_o(in_ready_o),
    .ld_we_o(ld_we_o), .ld_addr_o(ld_addr_o),
    .ld_bit_o(ld_bit_o),
    .dp_start_o(dp_start_o), .dp_done_i(dp_done_i),
    .syn_zero_i(syn_zero_i),
    .rd_addr_o(rd_addr_o), .dec_bit_i(dec_bit_i),
    .out_valid_o(out_valid_o), .out_bit_o(out_bit_o),
    .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o),
    .success_o(success_o), .iter_cnt_o(iter_cnt_o)
  );

  int pass_n = 0;
  int tot_n = 0;

  task automatic chk(string nm, int act, int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  logic mem [256];
  logic bits [256];
  int starts = 0, dones = 0, ndone = 0, ldn = 0;
  int cd = 0, synk = 0, nd0 = 0;

  // decoder "corrects" every odd bit
  assign dec_bit_i = mem[rd_addr_o] ^ rd_addr_o[0];

  // datapath model: memory, 3-cycle iteration, syndrome
  always @(negedge clk) begin
    if (ld_we_o) begin
      mem[ld_addr_o] = ld_bit_o;
      chk("ld_addr", int'(ld_addr_o), ldn % NN);
      chk("ld_bit", int'(ld_bit_o), int'(bits[ldn % NN]));
      ldn++;
    end
    if (done_o) dones++;
    dp_done_i = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        dp_done_i = 1'b1;
        ndone++;
        syn_zero_i = (synk != 0) && (ndone - nd0 >= synk);
      end
    end
    if (dp_start_o) begin
      starts++;
      cd = 3;
    end
  end

  typedef struct {
    int maxit;
    int sk;
    bit bp;
    int e_iter;
    bit e_succ;
    int e_starts;
  } vec_t;

  vec_t vt [6];

  task automatic start_run(int maxit, int sk);
    for (int i = 0; i < NN; i++) bits[i] = 1'($urandom_range(0, 1));
    synk = sk;
    nd0 = ndone;
    @(negedge clk);
    start_i = 1'b1;
    max_iter_i = IW'(maxit);
    @(negedge clk);
    start_i = 1'b0;
    chk("start_busy", int'(busy_o), 1);
    chk("start_ready", int'(in_ready_o), 1);
    chk("start_iter_clr", int'(iter_cnt_o), 0);
    chk("start_succ_clr", int'(success_o), 0);
  endtask

  task automatic load_phase(bit bp);
    int k = 0;
    int guard = 0;
    bit v;
    while (k < NN && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (in_ready_o) begin
        v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid_i = v;
        in_bit_i = bits[k];
        if (v) k++;
      end else begin
        in_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    chk("load_count", k, NN);
    chk("ready_after_load", int'(in_ready_o), 0);
  endtask

  task automatic drain_phase(bit bp, int maxout,
                             output int nout);
    logic pb;
    logic [7:0] pa;
    bit stall = 1'b0;
    bit r;
    int guard = 0;
    nout = 0;
    pb = 1'b0;
    pa = '0;
    while (guard < 3000 && !(maxout < NN && nout >= maxout)) begin
      @(negedge clk);
      guard++;
      if (done_o) break;
      if (out_valid_o) begin
        if (stall) begin
          chk("stall_bit", int'(out_bit_o), int'(pb));
          chk("stall_addr", int'(rd_addr_o), int'(pa));
        end
        r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready_i = r;
        if (r) begin
          chk("out_addr", int'(rd_addr_o), nout);
          chk("out_bit", int'(out_bit_o),
              int'(bits[nout] ^ (nout % 2 == 1)));
          nout++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          pb = out_bit_o;
          pa = rd_addr_o;
        end
      end else begin
        out_ready_i = 1'b0;
      end
    end
    if (maxout >= NN) out_ready_i = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int s0, d0, nout;
    logic [IW-1:0] it;
    s0 = starts;
    d0 = dones;
    start_run(v.maxit, v.sk);
    load_phase(v.bp);
    drain_phase(v.bp, NN, nout);
    chk("nout", nout, NN);
    chk("done_o", int'(done_o), 1);
    chk("busy_end", int'(busy_o), 0);
    chk("iter", int'(iter_cnt_o), v.e_iter);
    chk("success", int'(success_o), int'(v.e_succ));
    it = iter_cnt_o;
    repeat (6) @(negedge clk);
    chk("done_once", dones - d0, 1);
    chk("dp_starts", starts - s0, v.e_starts);
    chk("iter_hold", int'(iter_cnt_o), int'(it));
    chk("succ_hold", int'(success_o), int'(v.e_succ));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, d0, g, nout;
    vt[0] = '{8, 1, 1'b0, 1, 1'b1, 1};
    vt[1] = '{3, 0, 1'b0, 3, 1'b0, 3};
    vt[2] = '{8, 2, 1'b1, 2, 1'b1, 2};
    vt[3] = '{0, 0, 1'b0, 1, 1'b0, 1};
    vt[4] = '{4, 4, 1'b1, 4, 1'b1, 4};
    vt[5] = '{1, 1, 1'b1, 1, 1'b1, 1};

    #12;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ready", int'(in_ready_o), 0);
    chk("rst_valid", int'(out_valid_o), 0);
    chk("rst_iter", int'(iter_cnt_o), 0);
    chk("rst_rd_addr", int'(rd_addr_o), 0);
    chk("rst_ld_addr", int'(ld_addr_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // abort while waiting on the third iteration
    s0 = starts;
    d0 = dones;
    start_run(8, 0);
    load_phase(1'b0);
    g = 0;
    while (starts - s0 < 3 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("abort_reach", int'(starts - s0 >= 3), 1);
    chk("pre_abort_iter", int'(iter_cnt_o), 2);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_iter", int'(iter_cnt_o), 2);
    chk("abort_succ", int'(success_o), 0);
    chk("abort_done", int'(done_o), 0);
    repeat (8) @(negedge clk);
    chk("late_dp_done_busy", int'(busy_o), 0);
    chk("abort_no_done", dones - d0, 0);
    chk("abort_starts", starts - s0, 3);
    run_vec('{2, 2, 1'b0, 2, 1'b1, 2});

    // abort beats start in IDLE
    @(negedge clk);
    start_i = 1'b1;
    abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("abort_start_idle", int'(busy_o), 0);
    chk("abort_start_ready", int'(in_ready_o), 0);

    // reset pulse in the middle of the drain
    d0 = dones;
    start_run(1, 1);
    load_phase(1'b1);
    drain_phase(1'b1, 4, nout);
    chk("pre_rst_valid", int'(out_valid_o), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_valid", int'(out_valid_o), 0);
    chk("mid_rst_rd_addr", int'(rd_addr_o), 0);
    chk("mid_rst_iter", int'(iter_cnt_o), 0);
    chk("mid_rst_succ", int'(success_o), 0);
    chk("mid_rst_done", int'(done_o), 0);
    @(negedge clk);
    out_ready_i = 1'b0;
    rst_n = 1'b1;
    start_i = 1'b1;
    max_iter_i = IW'(1);
    @(negedge clk);
    start_i = 1'b0;
    chk("start_after_rst", int'(busy_o), 1);
    chk("rst_no_done", dones - d0, 0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("final_idle", int'(busy_o), 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
